// File: rtl/dec_scan_seq_if.sv
// Control and result bundle for dec_scan_seq. The driver (master) supplies select and
// scan controls; the decoder (slave) returns the registered one-hot lines and status.
interface dec_scan_seq_if #(
    parameter int N = 3
);
    logic              en;
    logic              mode;
    logic [N-1:0]      a;
    logic              load;
    logic              step;
    logic              dir;
    logic              wrap;
    logic [(1<<N)-1:0] d;
    logic [N-1:0]      idx;
    logic              busy;
    logic              done;

    modport master (
        output en, mode, a, load, step, dir, wrap,
        input  d, idx, busy, done
    );

    modport slave (
        input  en, mode, a, load, step, dir, wrap,
        output d, idx, busy, done
    );
endinterface

// File: rtl/dec_scan_seq.sv
// Registered N-to-2^N one-hot strobe generator: direct decode of a select, or a
// stepped up/down scan of a single active line with optional wrap at the terminal index.
module dec_scan_seq #(
    parameter int N       = 3,
    parameter int RST_IDX = 0
) (
    input  logic           clk,
    input  logic           rst,
    dec_scan_seq_if.slave  bus
);
    localparam int          W       = 1 << N;
    localparam logic [N-1:0] IDX_TOP = '1;
    localparam logic [N-1:0] IDX_BOT = '0;

    logic [N-1:0] idx_q, idx_d;
    logic [W-1:0] d_q, d_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         at_term;

    assign at_term = bus.dir ? (idx_q == IDX_TOP) : (idx_q == IDX_BOT);

    always_comb begin
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (!bus.mode) begin
            // Leaving scan mode (or staying in direct mode) always ends any scan silently.
            busy_d = 1'b0;
            if (bus.en) begin
                idx_d = bus.a;
            end
        end else if (bus.load) begin
            idx_d  = bus.a;
            busy_d = 1'b1;
        end else if (bus.step && busy_q && bus.en) begin
            if (!at_term) begin
                idx_d = bus.dir ? idx_q + 1'b1 : idx_q - 1'b1;
            end else begin
                done_d = 1'b1;
                if (bus.wrap) begin
                    idx_d = bus.dir ? IDX_BOT : IDX_TOP;
                end else begin
                    busy_d = 1'b0;
                end
            end
        end
    end

    // Decode the index being written this edge so d never lags idx.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_dec
            assign d_d[gi] = bus.en && (idx_d == N'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= N'(RST_IDX);
            d_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            d_q    <= d_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.d    = d_q;
    assign bus.idx  = idx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_dec_scan_seq.sv
// Bench for dec_scan_seq: directed vector table for the scan corner cases, then
// randomized traffic checked against a rule-level model of the decoder.
module tb_dec_scan_seq;
    localparam int N       = 3;
    localparam int W       = 1 << N;
    localparam int RST_IDX = 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    dec_scan_seq_if #(.N(N)) bus ();

    dec_scan_seq #(.N(N), .RST_IDX(RST_IDX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         rst;
        logic         en;
        logic         mode;
        logic [N-1:0] a;
        logic         load;
        logic         step;
        logic         dir;
        logic         wrap;
        logic [W-1:0] ed;
        logic [N-1:0] eidx;
        logic         ebusy;
        logic         edone;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e, logic m, int av, logic ld, logic st,
                                logic dr, logic wr, int ed, int ei, logic eb, logic edn);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.a = N'(av);
        v.load = ld; v.step = st; v.dir = dr; v.wrap = wr;
        v.ed = W'(ed); v.eidx = N'(ei); v.ebusy = eb; v.edone = edn;
        return v;
    endfunction

    task automatic drive(logic r, logic e, logic m, logic [N-1:0] av, logic ld,
                         logic st, logic dr, logic wr);
        rst = r; bus.en = e; bus.mode = m; bus.a = av;
        bus.load = ld; bus.step = st; bus.dir = dr; bus.wrap = wr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [W-1:0] ed, logic [N-1:0] ei, logic eb, logic edn);
        chk({tag, ".d"},    32'(bus.d),    32'(ed));
        chk({tag, ".idx"},  32'(bus.idx),  32'(ei));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
        chk({tag, ".done"}, 32'(bus.done), 32'(edn));
    endtask

    // Rule-level model: plain integer index, wrap via modulo.
    int m_idx, m_d;
    bit m_busy, m_done;

    task automatic model_edge(bit r, bit e, bit m, int av, bit ld, bit st, bit dr, bit wr);
        if (r) begin
            m_idx = RST_IDX; m_busy = 0; m_done = 0; m_d = 0;
            return;
        end
        m_done = 0;
        if (!m) begin
            m_busy = 0;
            if (e) m_idx = av;
        end else if (ld) begin
            m_idx = av; m_busy = 1;
        end else if (st && m_busy && e) begin
            int target;
            target = dr ? W - 1 : 0;
            if (m_idx != target) begin
                m_idx = (m_idx + (dr ? 1 : W - 1)) % W;
            end else begin
                m_done = 1;
                if (wr) m_idx = (m_idx + (dr ? 1 : W - 1)) % W;
                else    m_busy = 0;
            end
        end
        m_d = e ? (1 << m_idx) : 0;
    endtask

    initial begin
        // rst en mode a load step dir wrap | d idx busy done
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 2, 0, 0));
        for (int k = 0; k < W; k++)
            tbl.push_back(mk(0, 1, 0, k, 0, 0, 0, 0, 1 << k, k, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 0, 0, 0, 0, 8'h00, 7, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5, 0, 0, 0, 0, 8'h20, 5, 0, 0));
        // one-shot up scan from 6
        tbl.push_back(mk(0, 1, 1, 6, 1, 0, 1, 0, 8'h40, 6, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 8'h80, 7, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 8'h80, 7, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 8'h80, 7, 0, 0));
        // wrapping down scan from 1, step held
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 1, 8'h02, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 8'h80, 7, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 8'h40, 6, 1, 0));
        // load beats step
        tbl.push_back(mk(0, 1, 1, 5, 1, 0, 1, 1, 8'h20, 5, 1, 0));
        tbl.push_back(mk(0, 1, 1, 3, 1, 1, 1, 1, 8'h08, 3, 1, 0));
        // reset mid-scan at idx 4, then a step that must be ignored
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 8'h10, 4, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 8'h00, 2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 8'h04, 2, 0, 0));
        // en low during scan: step frozen, load still taken
        tbl.push_back(mk(0, 1, 1, 6, 1, 0, 1, 0, 8'h40, 6, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 8'h00, 6, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 8'h04, 2, 1, 0));
        // drop to direct mode mid-scan, then back to scan without load
        tbl.push_back(mk(0, 1, 0, 3, 0, 1, 1, 0, 8'h08, 3, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 8'h08, 3, 0, 0));

        drive(1, 0, 0, '0, 0, 0, 0, 0);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].a,
                  tbl[i].load, tbl[i].step, tbl[i].dir, tbl[i].wrap);
            tick();
            $display("vec %0d: rst=%0b en=%0b mode=%0b a=%0d load=%0b step=%0b dir=%0b wrap=%0b -> d=%b idx=%0d busy=%0b done=%0b",
                     i, tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].load,
                     tbl[i].step, tbl[i].dir, tbl[i].wrap, bus.d, bus.idx, bus.busy, bus.done);
            chk_all($sformatf("vec%0d", i), tbl[i].ed, tbl[i].eidx, tbl[i].ebusy, tbl[i].edone);
        end

        // Randomized traffic; the first cycle resets so model and DUT start aligned.
        for (int c = 0; c < 800; c++) begin
            bit r, e, m, ld, st, dr, wr;
            int av;
            r  = (c == 0) || ($urandom_range(63) == 0);
            e  = $urandom_range(7) != 0;
            m  = $urandom_range(3) != 0;
            ld = $urandom_range(7) == 0;
            st = $urandom_range(1) == 1;
            dr = $urandom_range(1) == 1;
            wr = $urandom_range(1) == 1;
            av = $urandom_range(W - 1);
            drive(r, e, m, N'(av), ld, st, dr, wr);
            model_edge(r, e, m, av, ld, st, dr, wr);
            tick();
            $display("rnd %0d: rst=%0b en=%0b mode=%0b a=%0d load=%0b step=%0b dir=%0b wrap=%0b -> d=%b idx=%0d busy=%0b done=%0b",
                     c, r, e, m, av, ld, st, dr, wr, bus.d, bus.idx, bus.busy, bus.done);
            chk_all($sformatf("rnd%0d", c), W'(m_d), N'(m_idx), m_busy, m_done);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
